// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for a multicycle RV32I datapath sharing one ALU and one memory port.
// Moore-style enables per state, except the branch PC load which follows the same-cycle ALU flags.
module multicycle_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       illegal_instr
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADR   = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] EXEC_R    = 4'd6;
    localparam logic [3:0] EXEC_I    = 4'd7;
    localparam logic [3:0] ALU_WB    = 4'd8;
    localparam logic [3:0] BRANCH    = 4'd9;
    localparam logic [3:0] JAL       = 4'd10;
    localparam logic [3:0] HALT      = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_reg;
    logic [3:0] state_next;

    logic       is_mem;
    logic       is_rtype;
    logic       is_itype;
    logic       is_branch;
    logic       is_jal;
    logic       op_legal;

    logic [1:0] alu_op;
    logic [2:0] funct_alu;
    logic       branch_take;

    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign is_rtype  = (op == OP_RTYPE);
    assign is_itype  = (op == OP_ITYPE);
    assign is_branch = (op == OP_BRANCH);
    assign is_jal    = (op == OP_JAL);
    assign op_legal  = is_mem || is_rtype || is_itype || is_branch || is_jal;

    // Immediate format follows the opcode in every state so the datapath can precompute it.
    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Subtract only for R-type with funct7 set; I-type addi never subtracts.
    always_comb begin
        case (funct3)
            3'b000:  funct_alu = (op[5] && funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b100:  funct_alu = ALU_XOR;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_OP_SUB:   alu_control = ALU_SUB;
            ALU_OP_FUNCT: alu_control = funct_alu;
            default:      alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_take = zero;
            3'b001:  branch_take = ~zero;
            3'b100:  branch_take = sign;
            default: branch_take = 1'b0;
        endcase
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = ALU_OP_ADD;
        illegal_instr = 1'b0;
        state_next    = state_reg;
        case (state_reg)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (is_mem) begin
                    state_next = MEM_ADR;
                end else if (is_rtype) begin
                    state_next = EXEC_R;
                end else if (is_itype) begin
                    state_next = EXEC_I;
                end else if (is_branch) begin
                    state_next = BRANCH;
                end else if (is_jal) begin
                    state_next = JAL;
                end else begin
                    state_next = ILLEGAL_HALT ? HALT : FETCH;
                end
                illegal_instr = ~op_legal;
            end
            MEM_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = op[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = MEM_WB;
                end
            end
            MEM_WB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                state_next    = FETCH;
            end
            MEM_WRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_op     = ALU_OP_FUNCT;
                state_next = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = ALU_OP_FUNCT;
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write_raw = 1'b1;
                state_next    = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 2'b10;
                alu_op       = ALU_OP_SUB;
                pc_write_raw = branch_take;
                state_next   = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4 for rd.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
                state_next   = ALU_WB;
            end
            HALT: begin
                illegal_instr = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Reset suppresses every architectural write so an aborted instruction leaves no side effects.
    assign pc_write  = pc_write_raw  & ~rst;
    assign mem_write = mem_write_raw & ~rst;
    assign ir_write  = ir_write_raw  & ~rst;
    assign reg_write = reg_write_raw & ~rst;
    assign state     = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: expected output vectors are queued as each cycle's stimulus is applied
// and popped/compared mid-cycle against two instances (illegal op returns vs. halts).
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       sign;
    logic       mem_ready;

    logic       pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, illegal0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, imm_src0;
    logic [2:0] alu_control0;
    logic [3:0] state0;

    logic       pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, illegal1;
    logic [1:0] result_src1, alu_src_a1, alu_src_b1, imm_src1;
    logic [2:0] alu_control1;
    logic [3:0] state1;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [20:0] exp0_q[$];
    logic [20:0] exp1_q[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .sign(sign), .mem_ready(mem_ready),
        .pc_write(pc_write0), .adr_src(adr_src0), .mem_write(mem_write0),
        .ir_write(ir_write0), .reg_write(reg_write0), .result_src(result_src0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .imm_src(imm_src0),
        .alu_control(alu_control0), .state(state0), .illegal_instr(illegal0)
    );

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .sign(sign), .mem_ready(mem_ready),
        .pc_write(pc_write1), .adr_src(adr_src1), .mem_write(mem_write1),
        .ir_write(ir_write1), .reg_write(reg_write1), .result_src(result_src1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .imm_src(imm_src1),
        .alu_control(alu_control1), .state(state1), .illegal_instr(illegal1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: state, pc_write, adr_src, mem_write, ir_write, reg_write,
    // result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr.
    function automatic logic [20:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic ill);
        return {st, pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic logic [20:0] e_fetch(input logic [1:0] imm, input logic wr);
        return ev(4'd0, wr, 1'b0, 1'b0, wr, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
    endfunction

    function automatic logic [20:0] e_decode(input logic [1:0] imm, input logic ill);
        return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic s, input logic mr);
        op = o; funct3 = f3; funct7 = f7; zero = z; sign = s; mem_ready = mr;
    endtask

    // Inputs are already applied; queue expectations, sample at negedge, advance one cycle.
    task automatic step2(input string tag, input logic [20:0] e0, input logic [20:0] e1);
        string       t;
        logic [20:0] x0, x1, o0, o1;
        tag_q.push_back(tag);
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        @(negedge clk);
        t  = tag_q.pop_front();
        x0 = exp0_q.pop_front();
        x1 = exp1_q.pop_front();
        o0 = {state0, pc_write0, adr_src0, mem_write0, ir_write0, reg_write0,
              result_src0, alu_src_a0, alu_src_b0, imm_src0, alu_control0, illegal0};
        o1 = {state1, pc_write1, adr_src1, mem_write1, ir_write1, reg_write1,
              result_src1, alu_src_a1, alu_src_b1, imm_src1, alu_control1, illegal1};
        checks++;
        assert (o0 === x0) else begin
            failures++;
            $error("FAIL %s dut0 observed=%h expected=%h", t, o0, x0);
        end
        checks++;
        assert (o1 === x1) else begin
            failures++;
            $error("FAIL %s dut1 observed=%h expected=%h", t, o1, x1);
        end
        $display("step %-18s state0=%0d state1=%0d", t, state0, state1);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [20:0] e);
        step2(tag, e, e);
    endtask

    initial begin
        logic [20:0] e_halt;
        e_halt = ev(4'd11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);

        rst = 1'b1;
        drive(LW, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        step("reset_hold", e_fetch(2'b00, 1'b0));
        rst = 1'b0;

        // lw with one wait state in MEM_READ
        step("lw_fetch", e_fetch(2'b00, 1'b1));
        step("lw_decode", e_decode(2'b00, 1'b0));
        step("lw_mem_adr", ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        mem_ready = 1'b0;
        step("lw_read_stall", ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        mem_ready = 1'b1;
        step("lw_read", ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        step("lw_mem_wb", ev(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));

        // fetch stall, then sw with mem_ready low for two MEM_WRITE cycles
        drive(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fetch_stall", e_fetch(2'b01, 1'b0));
        mem_ready = 1'b1;
        step("sw_fetch", e_fetch(2'b01, 1'b1));
        step("sw_decode", e_decode(2'b01, 1'b0));
        step("sw_mem_adr", ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        mem_ready = 1'b0;
        step("sw_write_w1", ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        step("sw_write_w2", ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        mem_ready = 1'b1;
        step("sw_write_done", ev(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));

        // R-type sub
        drive(RT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("r_fetch", e_fetch(2'b00, 1'b1));
        step("r_decode", e_decode(2'b00, 1'b0));
        step("r_exec_sub", ev(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
        step("r_alu_wb", ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

        // R-type slt
        drive(RT, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step("slt_fetch", e_fetch(2'b00, 1'b1));
        step("slt_decode", e_decode(2'b00, 1'b0));
        step("slt_exec", ev(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0));
        step("slt_alu_wb", ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

        // I-type ori, then addi with funct7 set (must stay add)
        drive(IT, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ori_fetch", e_fetch(2'b00, 1'b1));
        step("ori_decode", e_decode(2'b00, 1'b0));
        step("ori_exec", ev(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 0));
        step("ori_alu_wb", ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        drive(IT, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        step("addi_fetch", e_fetch(2'b00, 1'b1));
        step("addi_decode", e_decode(2'b00, 1'b0));
        step("addi_exec", ev(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        step("addi_alu_wb", ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

        // branches: blt taken/not taken, beq taken, bne not taken
        drive(BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
        step("blt_t_fetch", e_fetch(2'b10, 1'b1));
        step("blt_t_decode", e_decode(2'b10, 1'b0));
        step("blt_taken", ev(9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        drive(BR, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        step("blt_n_fetch", e_fetch(2'b10, 1'b1));
        step("blt_n_decode", e_decode(2'b10, 1'b0));
        step("blt_not_taken", ev(9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        drive(BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        step("beq_fetch", e_fetch(2'b10, 1'b1));
        step("beq_decode", e_decode(2'b10, 1'b0));
        step("beq_taken", ev(9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        drive(BR, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
        step("bne_fetch", e_fetch(2'b10, 1'b1));
        step("bne_decode", e_decode(2'b10, 1'b0));
        step("bne_not_taken", ev(9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

        // jal
        drive(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("jal_fetch", e_fetch(2'b11, 1'b1));
        step("jal_decode", e_decode(2'b11, 1'b0));
        step("jal_exec", ev(10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
        step("jal_alu_wb", ev(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));

        // reset while in MEM_READ with mem_ready high: abort to FETCH
        drive(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step("rr_fetch", e_fetch(2'b00, 1'b1));
        step("rr_decode", e_decode(2'b00, 1'b0));
        step("rr_mem_adr", ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        rst = 1'b1;
        step("rr_read_rst", ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        rst = 1'b0;
        step("rr_refetch", e_fetch(2'b00, 1'b1));
        step("rr_redecode", e_decode(2'b00, 1'b0));
        step("rr_mem_adr2", ev(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        step("rr_read2", ev(3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        // reset in MEM_WB must mask reg_write
        rst = 1'b1;
        step("rr_wb_rst", ev(4, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        rst = 1'b0;
        step("rr_fetch3", e_fetch(2'b00, 1'b1));

        // illegal opcode: dut0 returns to FETCH, dut1 parks in HALT until reset
        drive(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ill_decode", e_decode(2'b00, 1'b1));
        mem_ready = 1'b0;
        step2("ill_after1", e_fetch(2'b00, 1'b0), e_halt);
        mem_ready = 1'b1;
        step2("ill_after2", e_fetch(2'b00, 1'b1), e_halt);
        step2("ill_after3", e_decode(2'b00, 1'b1), e_halt);
        mem_ready = 1'b0;
        step2("ill_after4", e_fetch(2'b00, 1'b0), e_halt);
        rst = 1'b1;
        step2("halt_rst", e_fetch(2'b00, 1'b0), e_halt);
        rst = 1'b0;
        drive(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step("post_halt_fetch", e_fetch(2'b00, 1'b1));
        step("post_halt_decode", e_decode(2'b00, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
